sync_lock_ctrl: RTL and testbench

//  Frame-lock controller downstream of the CGA sync detector. Consumes its validated
//  V/H sync pulses and syncOk flag, measures lines per frame and locks once the count
//  is stable. Flywheels over missing V syncs and drives frame/line timing for the scaler
//  and HDMI output stage.

---
 rtl/sync_lock_ctrl_pkg.sv | 34 +++
 rtl/sync_lock_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sync_lock_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_lock_ctrl_pkg.sv
// Shared timing limits, state encoding and small helpers for the frame-lock controller.
package sync_lock_ctrl_pkg;

   localparam int unsigned MIN_LINES   = 256;
   localparam int unsigned MAX_LINES   = 263;
   localparam int unsigned LINE_TOL    = 1;
   localparam int unsigned LOCK_FRAMES = 4;
   localparam int unsigned HOLD_FRAMES = 2;
   localparam int unsigned H_TIMEOUT   = 8190;

   localparam int unsigned LW       = $clog2(MAX_LINES + LINE_TOL + 2);
   localparam int unsigned LINE_SAT = MAX_LINES + LINE_TOL + 1;
   localparam int unsigned GAP_W    = $clog2(H_TIMEOUT + 1);
   localparam int unsigned GOOD_W   = $clog2(LOCK_FRAMES + 1);
   localparam int unsigned MISS_W   = $clog2(HOLD_FRAMES + 1);
   localparam int unsigned LOSS_W   = 8;

   typedef enum logic [1:0] {
      ST_SEARCH   = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_HOLDOVER = 2'd3
   } lock_state_e;

   // Timing is driven downstream in both of these states.
   function automatic logic is_live(input lock_state_e s);
      return (s == ST_LOCKED) || (s == ST_HOLDOVER);
   endfunction

   function automatic logic [LW-1:0] abs_diff(input logic [LW-1:0] a, input logic [LW-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/sync_lock_ctrl.sv
// Frame-lock controller: measures lines per frame from validated V/H sync pulses, locks on a
// stable count, flywheels over missing V syncs and drives frame/line timing downstream.
module sync_lock_ctrl
   import sync_lock_ctrl_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              vSyncPulse,
   input  logic              hSyncPulse,
   input  logic              syncOk,
   output logic              locked,
   output logic              frameStart,
   output logic              lineStart,
   output logic [LW-1:0]     lineNum,
   output logic [LW-1:0]     frameLines,
   output logic [1:0]        state,
   output logic [LOSS_W-1:0] lossCount
);

   lock_state_e         state_q, state_d;
   logic [LW-1:0]       line_cnt_q, line_cnt_d;
   logic [LW-1:0]       ref_lines_q, ref_lines_d;
   logic [LW-1:0]       frame_lines_q, frame_lines_d;
   logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
   logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
   logic [GAP_W-1:0]    h_gap_q, h_gap_d;
   logic                meas_valid_q, meas_valid_d;
   logic [LOSS_W-1:0]   loss_q, loss_d;
   logic                locked_q, locked_d;
   logic                frame_start_q, frame_start_d;
   logic                line_start_q, line_start_d;

   logic                timeout;
   logic                live;
   logic                fly;
   logic                frame_evt;
   logic                line_evt;
   logic                range_ok;
   logic                tol_ok;
   logic                good_frame;
   logic [LW:0]         line_next;
   logic [LW:0]         fly_limit;
   logic [GOOD_W-1:0]   good_inc;
   logic [MISS_W-1:0]   miss_inc;

   assign timeout   = (h_gap_q == GAP_W'(H_TIMEOUT));
   assign live      = is_live(state_q);
   assign line_next = {1'b0, line_cnt_q} + (LW+1)'(1);
   assign fly_limit = {1'b0, frame_lines_q} + (LW+1)'(LINE_TOL);

   // An H pulse that overruns the locked frame length stands in for the missing V sync.
   assign fly       = hSyncPulse && !vSyncPulse && live && (line_next > fly_limit);
   assign frame_evt = vSyncPulse || fly;
   assign line_evt  = hSyncPulse && !frame_evt;

   assign range_ok   = (line_cnt_q >= LW'(MIN_LINES)) && (line_cnt_q <= LW'(MAX_LINES));
   assign tol_ok     = (abs_diff(line_cnt_q, ref_lines_q) <= LW'(LINE_TOL));
   assign good_frame = vSyncPulse && syncOk && range_ok && ((state_q == ST_SEARCH) || tol_ok);

   assign good_inc = good_cnt_q + GOOD_W'(1);
   assign miss_inc = miss_cnt_q + MISS_W'(1);

   // Line counter and H-gap watchdog.
   always_comb begin
      line_cnt_d = line_cnt_q;
      h_gap_d    = h_gap_q;

      if (frame_evt) begin
         line_cnt_d = '0;
      end else if (line_evt && (line_cnt_q != LW'(LINE_SAT))) begin
         line_cnt_d = line_next[LW-1:0];
      end

      if (hSyncPulse) begin
         h_gap_d = '0;
      end else if (!timeout) begin
         h_gap_d = h_gap_q + GAP_W'(1);
      end
   end

   // Lock FSM: decisions are taken only on frame events; the H watchdog overrides everything.
   always_comb begin
      state_d       = state_q;
      ref_lines_d   = ref_lines_q;
      frame_lines_d = frame_lines_q;
      good_cnt_d    = good_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      meas_valid_d  = meas_valid_q;
      loss_d        = loss_q;

      if (timeout) begin
         state_d      = ST_SEARCH;
         meas_valid_d = 1'b0;
         good_cnt_d   = '0;
         miss_cnt_d   = '0;
      end else if (frame_evt) begin
         case (state_q)
            ST_SEARCH: begin
               if (!meas_valid_q) begin
                  meas_valid_d = 1'b1;
               end else if (good_frame) begin
                  state_d     = ST_ACQUIRE;
                  ref_lines_d = line_cnt_q;
                  good_cnt_d  = GOOD_W'(1);
               end
            end
            ST_ACQUIRE: begin
               if (good_frame) begin
                  good_cnt_d = good_inc;
                  if (good_inc == GOOD_W'(LOCK_FRAMES)) begin
                     state_d       = ST_LOCKED;
                     frame_lines_d = ref_lines_q;
                  end
               end else begin
                  state_d    = ST_SEARCH;
                  good_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               if (!good_frame) begin
                  state_d    = ST_HOLDOVER;
                  miss_cnt_d = MISS_W'(1);
                  if (loss_q != '1) begin
                     loss_d = loss_q + LOSS_W'(1);
                  end
               end
            end
            ST_HOLDOVER: begin
               if (good_frame) begin
                  state_d    = ST_LOCKED;
                  miss_cnt_d = '0;
               end else if (miss_inc == MISS_W'(HOLD_FRAMES)) begin
                  state_d      = ST_SEARCH;
                  meas_valid_d = 1'b0;
                  good_cnt_d   = '0;
                  miss_cnt_d   = '0;
               end else begin
                  miss_cnt_d = miss_inc;
               end
            end
            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end
   end

   // Output pulses: the frame that completes acquisition already gets a frameStart.
   always_comb begin
      frame_start_d = frame_evt && !timeout && (live || (state_d == ST_LOCKED));
      line_start_d  = line_evt && live && !timeout;
      locked_d      = is_live(state_d);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_SEARCH;
         line_cnt_q    <= '0;
         ref_lines_q   <= '0;
         frame_lines_q <= '0;
         good_cnt_q    <= '0;
         miss_cnt_q    <= '0;
         h_gap_q       <= '0;
         meas_valid_q  <= 1'b0;
         loss_q        <= '0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_cnt_q    <= line_cnt_d;
         ref_lines_q   <= ref_lines_d;
         frame_lines_q <= frame_lines_d;
         good_cnt_q    <= good_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         h_gap_q       <= h_gap_d;
         meas_valid_q  <= meas_valid_d;
         loss_q        <= loss_d;
         locked_q      <= locked_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
      end
   end

   assign locked     = locked_q;
   assign frameStart = frame_start_q;
   assign lineStart  = line_start_q;
   assign lineNum    = line_cnt_q;
   assign frameLines = frame_lines_q;
   assign state      = state_q;
   assign lossCount  = loss_q;

endmodule

// File: tb/tb_sync_lock_ctrl.sv
// Bench for sync_lock_ctrl: directed lock/flywheel/timeout scenarios followed by randomized
// frames, every cycle compared against a frame-event reference model.
module tb_sync_lock_ctrl;

   localparam int T_MIN   = 256;
   localparam int T_MAX   = 263;
   localparam int T_TOL   = 1;
   localparam int T_LOCKN = 4;
   localparam int T_HOLDN = 2;
   localparam int T_TMO   = 8190;
   localparam int T_SAT   = 265;

   localparam int K_NONE = 0;
   localparam int K_LINE = 1;
   localparam int K_V    = 2;
   localparam int K_FLY  = 3;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       vSyncPulse = 1'b0;
   logic       hSyncPulse = 1'b0;
   logic       syncOk = 1'b1;
   logic       locked;
   logic       frameStart;
   logic       lineStart;
   logic [8:0] lineNum;
   logic [8:0] frameLines;
   logic [1:0] state;
   logic [7:0] lossCount;

   sync_lock_ctrl dut (
      .CLK        (CLK),
      .RST        (RST),
      .vSyncPulse (vSyncPulse),
      .hSyncPulse (hSyncPulse),
      .syncOk     (syncOk),
      .locked     (locked),
      .frameStart (frameStart),
      .lineStart  (lineStart),
      .lineNum    (lineNum),
      .frameLines (frameLines),
      .state      (state),
      .lossCount  (lossCount)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: 0 SEARCH, 1 ACQUIRE, 2 LOCKED, 3 HOLDOVER
   int m_state, m_cnt, m_ref, m_good, m_miss, m_gap, m_meas, m_flines, m_loss, m_fs, m_ls;
   bit watch_locked   = 1'b0;
   bit locked_dropped = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_ref = 0; m_good = 0; m_miss = 0; m_gap = 0;
      m_meas = 0; m_flines = 0; m_loss = 0; m_fs = 0; m_ls = 0;
   endtask

   task automatic model_step(input bit v, input bit h, input bit ok);
      bit tmo, live, good;
      int kind, dev;
      tmo  = (m_gap == T_TMO);
      live = (m_state == 2) || (m_state == 3);
      if (v)                                           kind = K_V;
      else if (h && live && (m_cnt + 1 > m_flines + T_TOL)) kind = K_FLY;
      else if (h)                                      kind = K_LINE;
      else                                             kind = K_NONE;
      dev  = (m_cnt > m_ref) ? m_cnt - m_ref : m_ref - m_cnt;
      good = v && ok && (m_cnt >= T_MIN) && (m_cnt <= T_MAX) && ((m_state == 0) || (dev <= T_TOL));
      m_fs = 0;
      m_ls = 0;
      if (tmo) begin
         m_state = 0; m_meas = 0; m_good = 0; m_miss = 0;
      end else if (kind == K_V || kind == K_FLY) begin
         case (m_state)
            0: if (m_meas == 0) m_meas = 1;
               else if (good) begin m_state = 1; m_ref = m_cnt; m_good = 1; end
            1: if (good) begin
                  m_good++;
                  if (m_good == T_LOCKN) begin m_state = 2; m_flines = m_ref; end
               end else begin
                  m_state = 0; m_good = 0;
               end
            2: if (!good) begin
                  m_state = 3; m_miss = 1;
                  if (m_loss < 255) m_loss++;
               end
            default: if (good) begin
                  m_state = 2; m_miss = 0;
               end else begin
                  m_miss++;
                  if (m_miss == T_HOLDN) begin m_state = 0; m_meas = 0; m_good = 0; m_miss = 0; end
               end
         endcase
         m_fs = (live || m_state == 2) ? 1 : 0;
      end else if (kind == K_LINE) begin
         m_ls = live ? 1 : 0;
      end
      if (kind == K_V || kind == K_FLY) m_cnt = 0;
      else if (kind == K_LINE && m_cnt < T_SAT) m_cnt++;
      if (h) m_gap = 0;
      else if (m_gap < T_TMO) m_gap++;
   endtask

   task automatic tick(input bit v, input bit h, input bit ok);
      vSyncPulse = v;
      hSyncPulse = h;
      syncOk     = ok;
      @(posedge CLK);
      model_step(v, h, ok);
      #1;
      check_val("state",      state,      m_state);
      check_val("locked",     locked,     (m_state >= 2) ? 1 : 0);
      check_val("frameStart", frameStart, m_fs);
      check_val("lineStart",  lineStart,  m_ls);
      check_val("lineNum",    lineNum,    m_cnt);
      check_val("frameLines", frameLines, m_flines);
      check_val("lossCount",  lossCount,  m_loss);
      if (watch_locked && !locked) locked_dropped = 1'b1;
   endtask

   task automatic lines(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat (gap) tick(1'b0, 1'b0, 1'b1);
         tick(1'b0, 1'b1, 1'b1);
      end
   endtask

   task automatic vsync(input bit ok);
      tick(1'b1, 1'b0, ok);
   endtask

   task automatic apply_reset();
      vSyncPulse = 1'b0;
      hSyncPulse = 1'b0;
      syncOk     = 1'b1;
      RST        = 1'b1;
      #1;
      check_val("rst_state",      state,      0);
      check_val("rst_locked",     locked,     0);
      check_val("rst_lineNum",    lineNum,    0);
      check_val("rst_lossCount",  lossCount,  0);
      check_val("rst_frameLines", frameLines, 0);
      check_val("rst_frameStart", frameStart, 0);
      check_val("rst_lineStart",  lineStart,  0);
      model_reset();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   initial begin
      int n, g, r;
      bit ok, hv;
      model_reset();
      #2;
      apply_reset();

      // Reset in the middle of a frame with a running line count
      vsync(1'b1);
      lines(100, 1);
      check_val("t1_pre_lineNum", lineNum, 100);
      apply_reset();

      // Acquire and lock on 262-line frames
      vsync(1'b1);
      check_val("t2_v1_state", state, 0);
      for (int k = 2; k <= 7; k++) begin
         lines(262, 1);
         vsync(1'b1);
         check_val("t2_state", state, (k < 5) ? 1 : 2);
         if (k >= 5) check_val("t2_frameStart", frameStart, 1);
      end
      check_val("t2_frameLines", frameLines, 262);

      // One 263-line frame is within tolerance; then a missing V flywheels
      watch_locked = 1'b1;
      lines(263, 1);
      vsync(1'b1);
      check_val("t3_263_state", state, 2);
      lines(264, 1);
      check_val("t3_fly_frameStart", frameStart, 1);
      check_val("t3_fly_state", state, 3);
      check_val("t3_fly_loss", lossCount, 1);

      // Recover from holdover without dropping lock, then a syncOk=0 vSync
      lines(262, 1);
      vsync(1'b1);
      check_val("t4_relock_state", state, 2);
      check_val("t4_locked_dropped", locked_dropped, 0);
      watch_locked = 1'b0;
      lines(262, 1);
      vsync(1'b0);
      check_val("t4_badok_state", state, 3);
      check_val("t4_badok_loss", lossCount, 2);

      // Two consecutive missing V syncs unlock
      lines(262, 1);
      vsync(1'b1);
      check_val("t5_lock_state", state, 2);
      lines(264, 1);
      check_val("t5_miss1_state", state, 3);
      lines(264, 1);
      check_val("t5_miss2_state", state, 0);
      check_val("t5_miss2_locked", locked, 0);
      check_val("t5_flines_hold", frameLines, 262);
      lines(262, 1);

      // Relock, then H watchdog timeout; then coincident V and H
      vsync(1'b1);
      for (int k = 0; k < 5; k++) begin
         lines(262, 1);
         vsync(1'b1);
      end
      check_val("t6_lock_state", state, 2);
      repeat (8195) tick(1'b0, 1'b0, 1'b1);
      check_val("t6_tmo_state", state, 0);
      check_val("t6_tmo_locked", locked, 0);
      lines(5, 1);
      tick(1'b1, 1'b1, 1'b1);
      check_val("t6_vh_lineNum", lineNum, 0);
      check_val("t6_vh_lineStart", lineStart, 0);

      // Randomized frames: mostly nominal with jittered lengths, dropped V, bad syncOk
      for (int f = 0; f < 30; f++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)       n = 262;
         else if (r == 6) n = 263;
         else if (r == 7) n = 261;
         else if (r == 8) n = int'($urandom_range(250, 270));
         else             n = int'($urandom_range(256, 263));
         for (int i = 0; i < n; i++) begin
            g = int'($urandom_range(0, 2));
            repeat (g) tick(1'b0, 1'b0, 1'b1);
            tick(1'b0, 1'b1, 1'b1);
         end
         tick(1'b0, 1'b0, 1'b1);
         if ($urandom_range(0, 9) != 0) begin
            ok = ($urandom_range(0, 9) != 0);
            hv = ($urandom_range(0, 9) == 0);
            tick(1'b1, hv, ok);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
